// File: rtl/ltssm_detect_ctrl_pkg.sv
// ltssm_detect_ctrl_pkg: Detect-state encoding, timer interval codes and receiver-detect status.
package ltssm_detect_ctrl_pkg;
  typedef enum logic [2:0] {QUIET, DETECT, EVAL, WAIT12, DONE} state_e;
  localparam logic [2:0] T0MS = 3'b000;
  localparam logic [2:0] T12MS = 3'b001;
  localparam logic [2:0] T2MS = 3'b100;
  localparam logic [2:0] RXDET_STATUS = 3'b011;
  function automatic logic timed(input state_e s);
    return s inside {QUIET, DETECT, WAIT12};
  endfunction
endpackage

// File: rtl/ltssm_detect_ctrl.sv
// ltssm_detect_ctrl: LTSSM Detect.Quiet/Detect.Active controller driving PIPE receiver detection and the interval timer.
module ltssm_detect_ctrl #(
  parameter int LANES = 4,
  parameter logic [2:0] RXDET_STATUS = ltssm_detect_ctrl_pkg::RXDET_STATUS
) (
  input  logic               Pclk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               Restart,
  input  logic [LANES-1:0]   RxElecIdle,
  input  logic [LANES-1:0]   PhyStatus,
  input  logic [3*LANES-1:0] RxStatus,
  input  logic               TimeOut,
  output logic               TimerStart,
  output logic               TimerEnable,
  output logic [2:0]         TimerIntervalCode,
  output logic               TxDetectRx,
  output logic [LANES-1:0]   TxElecIdle,
  output logic               DetectDone,
  output logic [LANES-1:0]   LaneMask
);
  import ltssm_detect_ctrl_pkg::*;
  state_e state_q, state_d;
  logic [LANES-1:0] seen_q, seen_d, found_q, found_d, first_q, first_d, mask_q, mask_d;
  logic attempt_q, attempt_d, start_q, start_d, ten_q, ten_d, tx_q, tx_d, done_q, done_d;
  logic [2:0] code_q, code_d;
  logic to;
  always_comb begin
    to = TimeOut && ten_q && !start_q;
    state_d = state_q;
    seen_d = seen_q;
    found_d = found_q;
    first_d = first_q;
    attempt_d = attempt_q;
    case (state_q)
      QUIET: state_d = (to || !(&RxElecIdle)) ? DETECT : QUIET;
      DETECT: begin
        for (int i = 0; i < LANES; i++)
          if (PhyStatus[i] && !seen_q[i]) begin
            seen_d[i] = 1'b1;
            found_d[i] = RxStatus[3*i +: 3] == RXDET_STATUS;
          end
        state_d = (&seen_q || to) ? EVAL : DETECT;
      end
      EVAL: begin
        if (&found_q) state_d = DONE;
        else if (found_q == '0) state_d = QUIET;
        else if (!attempt_q) begin
          first_d = found_q;
          attempt_d = 1'b1;
          state_d = WAIT12;
        end else state_d = (found_q == first_q) ? DONE : QUIET;
      end
      WAIT12: state_d = to ? DETECT : WAIT12;
      DONE: state_d = Restart ? QUIET : DONE;
      default: state_d = QUIET;
    endcase
    if (!Enable) state_d = QUIET;
    // each Detect.Active attempt starts from a clean slate
    if (state_d == DETECT && state_q != DETECT) begin
      seen_d = '0;
      found_d = '0;
    end
    if (state_d == QUIET) attempt_d = 1'b0;
    ten_d = Enable && timed(state_d);
    start_d = ten_d && (state_d != state_q || !ten_q);
    code_d = state_d == DETECT ? T2MS : timed(state_d) ? T12MS : T0MS;
    tx_d = state_d == DETECT;
    done_d = state_d == DONE;
    mask_d = state_d != DONE ? '0 : state_q == DONE ? mask_q : found_q;
  end
  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      state_q <= QUIET;
      seen_q <= '0;
      found_q <= '0;
      first_q <= '0;
      mask_q <= '0;
      attempt_q <= 1'b0;
      start_q <= 1'b0;
      ten_q <= 1'b0;
      tx_q <= 1'b0;
      done_q <= 1'b0;
      code_q <= T0MS;
    end else begin
      state_q <= state_d;
      seen_q <= seen_d;
      found_q <= found_d;
      first_q <= first_d;
      mask_q <= mask_d;
      attempt_q <= attempt_d;
      start_q <= start_d;
      ten_q <= ten_d;
      tx_q <= tx_d;
      done_q <= done_d;
      code_q <= code_d;
    end
  end
  assign TimerStart = start_q;
  assign TimerEnable = ten_q;
  assign TimerIntervalCode = code_q;
  assign TxDetectRx = tx_q;
  assign TxElecIdle = '1;
  assign DetectDone = done_q;
  assign LaneMask = mask_q;
endmodule

// File: tb/tb_ltssm_detect_ctrl.sv
// tb_ltssm_detect_ctrl: directed bench with a Gen1/8-bit interval timer model (12 ms = 24, 2 ms = 4 cycles).
module tb_ltssm_detect_ctrl;
  import ltssm_detect_ctrl_pkg::*;
  logic Pclk = 0, Reset = 0, Enable = 1, Restart = 0;
  logic [3:0] RxElecIdle = 4'hF, PhyStatus = 4'h0;
  logic [11:0] RxStatus = 12'h0;
  logic TimeOut, TimerStart, TimerEnable, TxDetectRx, DetectDone;
  logic [2:0] TimerIntervalCode;
  logic [3:0] TxElecIdle, LaneMask;
  logic [7:0] cnt, lim;
  int total = 0, bad = 0, n;

  ltssm_detect_ctrl #(.LANES(4)) dut (
    .Pclk(Pclk), .Reset(Reset), .Enable(Enable), .Restart(Restart),
    .RxElecIdle(RxElecIdle), .PhyStatus(PhyStatus), .RxStatus(RxStatus),
    .TimeOut(TimeOut), .TimerStart(TimerStart), .TimerEnable(TimerEnable),
    .TimerIntervalCode(TimerIntervalCode), .TxDetectRx(TxDetectRx),
    .TxElecIdle(TxElecIdle), .DetectDone(DetectDone), .LaneMask(LaneMask)
  );

  always #5 Pclk = ~Pclk;

  assign lim = TimerIntervalCode == 3'b001 ? 8'd24 : TimerIntervalCode == 3'b100 ? 8'd4 : 8'd0;
  assign TimeOut = cnt >= lim;
  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) cnt <= 8'd0;
    else if (TimerStart) cnt <= 8'd0;
    else if (TimerEnable && !TimeOut) cnt <= cnt + 8'd1;
  end

  task automatic tick;
    @(posedge Pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic phy(input logic [3:0] m, input logic [3:0] f);
    PhyStatus = m;
    for (int i = 0; i < 4; i++) RxStatus[3*i +: 3] = f[i] ? 3'b011 : 3'b000;
    tick;
    PhyStatus = 4'h0;
    RxStatus = 12'h0;
  endtask

  function automatic logic cond(input int sel);
    if (sel == 0) return TxDetectRx;
    if (sel == 1) return TimerStart && TimerIntervalCode == 3'b001;
    return DetectDone;
  endfunction

  task automatic wait_until(input string tag, input int sel, input int bound);
    int k = 0;
    while (!cond(sel) && k < bound) begin
      tick;
      k++;
    end
    chk(tag, cond(sel), 1);
  endtask

  task automatic exit_idle;
    RxElecIdle = 4'b1100;
    tick;
    RxElecIdle = 4'hF;
  endtask

  localparam logic [15:0] RST_OUT = {1'b0, 1'b0, 3'b000, 1'b0, 4'hF, 1'b0, 4'h0};

  initial begin
    repeat (3) tick;
    chk("reset_outs", {TimerStart, TimerEnable, TimerIntervalCode, TxDetectRx, TxElecIdle, DetectDone, LaneMask}, RST_OUT);
    chk("reset_state", dut.state_q, QUIET);
    Reset = 1;
    tick;
    chk("t1_start", {TimerStart, TimerEnable, TimerIntervalCode}, 5'b11001);
    n = 0;
    while (!TxDetectRx && n < 40) begin
      if (TimeOut && !TimerStart) RxElecIdle = 4'b1011;
      tick;
      n++;
    end
    RxElecIdle = 4'hF;
    chk("t1_latency_ok", n >= 24 && n <= 26, 1);
    chk("t1_detect_entry", {TxDetectRx, TimerStart, TimerIntervalCode}, 5'b11100);
    tick;
    chk("t1_single_transition", {TxDetectRx, TimerStart, TimerEnable}, 3'b101);
    wait_until("t1_guard_back_to_quiet", 1, 20);
    chk("t1_quiet_no_tx", TxDetectRx, 0);
    tick;
    tick;
    RxElecIdle = 4'b1011;
    tick;
    RxElecIdle = 4'hF;
    chk("t2_idle_exit", {TxDetectRx, TimerStart, TimerIntervalCode}, 5'b11100);
    phy(4'hF, 4'hF);
    chk("t3_not_done_yet", DetectDone, 0);
    tick;
    chk("t3_eval_tx_drop", TxDetectRx, 0);
    tick;
    chk("t3_done", {DetectDone, LaneMask, TimerEnable}, 6'b111110);
    Restart = 1;
    tick;
    Restart = 0;
    chk("t3_restart", {DetectDone, LaneMask, TimerStart, TimerIntervalCode}, 9'b000001001);
    exit_idle;
    phy(4'hF, 4'b0011);
    tick;
    tick;
    chk("t4_wait12_entry", {TimerStart, TimerIntervalCode, TxDetectRx}, 5'b10010);
    Restart = 1;
    tick;
    Restart = 0;
    chk("t4_restart_ignored", {TimerStart, DetectDone, TxDetectRx, TimerEnable}, 4'b0001);
    wait_until("t4_wait12_expire", 0, 40);
    chk("t4_second_detect", {TimerStart, TimerIntervalCode}, 4'b1100);
    phy(4'hF, 4'b0011);
    tick;
    tick;
    chk("t4_match_done", {DetectDone, LaneMask}, 5'b10011);
    Restart = 1;
    tick;
    Restart = 0;
    exit_idle;
    phy(4'hF, 4'b0011);
    tick;
    tick;
    wait_until("t4b_wait12_expire", 0, 40);
    phy(4'hF, 4'b0001);
    tick;
    tick;
    chk("t4b_mismatch_quiet", {DetectDone, LaneMask, TimerStart, TimerIntervalCode}, 9'b000001001);
    exit_idle;
    phy(4'b0111, 4'b0111);
    phy(4'b0001, 4'b0000);
    wait_until("t5_guard_to_wait12", 1, 20);
    chk("t5_wait12_no_tx", {TxDetectRx, DetectDone}, 2'b00);
    wait_until("t5_wait12_expire", 0, 40);
    phy(4'b0111, 4'b0111);
    wait_until("t5_done", 2, 20);
    chk("t5_mask", LaneMask, 4'b0111);
    Restart = 1;
    tick;
    Restart = 0;
    exit_idle;
    chk("t6_in_detect", TxDetectRx, 1);
    Enable = 0;
    tick;
    chk("t6_disable", {TxDetectRx, TimerEnable, DetectDone}, 3'b000);
    chk("t6_state_quiet", dut.state_q, QUIET);
    tick;
    Enable = 1;
    tick;
    chk("t6_enable_restart", {TimerStart, TimerEnable, TimerIntervalCode}, 5'b11001);
    exit_idle;
    Reset = 0;
    #1;
    chk("t6_async_reset_detect", TxDetectRx, 0);
    Reset = 1;
    tick;
    tick;
    exit_idle;
    phy(4'hF, 4'hF);
    wait_until("t6_done_again", 2, 10);
    Reset = 0;
    #1;
    chk("t6_async_reset_done", {TimerStart, TimerEnable, TimerIntervalCode, TxDetectRx, TxElecIdle, DetectDone, LaneMask}, RST_OUT);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ltssm_detect_ctrl.md
Name: ltssm_detect_ctrl

Overview:
- LTSSM Detect-state controller (Detect.Quiet / Detect.Active). It is the client end of the shared interval timer: it drives the timer's Start, Enable and TimerIntervalCode, and consumes its TimeOut.
- It drives PIPE receiver detection (TxDetectRx / PhyStatus / RxStatus) on every lane.
- It reports the detected-lane mask to the Polling logic.

Parameters:
- LANES, 4, number of PIPE lanes handled.
- RXDET_STATUS, 3'b011, RxStatus value meaning "receiver detected".

Ports:
- Pclk  input  1  PIPE clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Enable  input  1  LTSSM enable; when 0 the FSM is forced to QUIET and the timer is disabled.
- Restart  input  1  one-cycle pulse from the upper LTSSM; leaves DONE and returns to QUIET.
- RxElecIdle  input  LANES  per-lane PIPE electrical-idle indication (1 = idle).
- PhyStatus  input  LANES  per-lane PIPE PhyStatus pulse.
- RxStatus  input  3*LANES  per-lane PIPE RxStatus; lane i occupies bits [3i+2:3i].
- TimeOut  input  1  from the interval timer.
- TimerStart  output  1  one-cycle pulse that clears the timer.
- TimerEnable  output  1  timer count enable.
- TimerIntervalCode  output  3  timer code: 001 = 12 ms, 100 = 2 ms, 000 = 0 ms.
- TxDetectRx  output  1  receiver-detect request, common to all lanes.
- TxElecIdle  output  LANES  held at all-ones throughout Detect.
- DetectDone  output  1  high while in DONE.
- LaneMask  output  LANES  lanes on which a receiver was detected; valid while DetectDone = 1.

Behaviour:

Reset values:
- state = QUIET, TimerStart = 0, TimerEnable = 0, TimerIntervalCode = 000.
- TxDetectRx = 0, TxElecIdle = all-ones, DetectDone = 0, LaneMask = 0.
- Internal registers: first_mask = 0, attempt = 0.

Timer rules:
- TimerStart is a registered one-cycle pulse, issued in the first cycle of QUIET, DETECT and WAIT12.
- TimerIntervalCode is registered and is stable by the cycle TimerStart is high.
- TimeOut is ignored in any cycle where TimerStart = 1.
- TimerEnable = 1 in QUIET, DETECT and WAIT12; 0 otherwise.

State QUIET:
- Code = 12 ms; attempt is cleared on entry.
- Go to DETECT on the first of: TimeOut, or any lane with RxElecIdle = 0.

State DETECT:
- Code = 2 ms guard; TxDetectRx = 1.
- A per-lane seen vector latches PhyStatus[i]. On that same cycle, found[i] <= (RxStatus lane i == RXDET_STATUS).
- Go to EVAL in the cycle after seen becomes all-ones, or on guard TimeOut. Lanes without PhyStatus count as found = 0.
- TxDetectRx drops on the cycle EVAL is entered.

State EVAL (one cycle):
- found all-ones: go to DONE, LaneMask <= found.
- found zero: go to QUIET.
- Partial and attempt = 0: first_mask <= found, attempt <= 1, go to WAIT12.
- Partial and attempt = 1: if found == first_mask, go to DONE with LaneMask <= found; otherwise go to QUIET.

State WAIT12:
- Code = 12 ms; on TimeOut go to DETECT, clearing seen and found.

State DONE:
- DetectDone = 1; LaneMask is held.
- Restart goes to QUIET, clearing LaneMask and DetectDone.

Simultaneous events and boundary cases:
- Enable = 0 overrides everything: next state is QUIET and TimerEnable = 0. When Enable rises, TimerStart is re-pulsed.
- Restart outside DONE is ignored.
- In QUIET, electrical-idle exit and TimeOut in the same cycle resolve to a single transition to DETECT.
- PhyStatus on a lane already marked seen is ignored.
- Asynchronous reset mid-DETECT drops TxDetectRx immediately.

Latency:
- Exiting QUIET on electrical-idle exit gives TxDetectRx = 1 one cycle later.

Decomposition:
- Shared ltssm package holds:
  - the state encoding for QUIET, DETECT, EVAL, WAIT12, DONE;
  - timer code constants T0MS = 000, T12MS = 001, T2MS = 100;
  - the RXDET_STATUS constant.
- No sub-module. The interval timer is instantiated beside this block, not inside it.

Test Plan:
All tests use a real timer instance at Gen1 with 8-bit pipe width (12 ms = 24 cycles, 2 ms = 4 cycles), LANES = 4.
1. Reset release with RxElecIdle = 1111 and no PhyStatus → TimerStart pulses; TxDetectRx rises 24–26 cycles later.
2. In QUIET, RxElecIdle goes to 1011 → next cycle TxDetectRx = 1 and TimerStart pulses with code 100.
3. All four lanes return PhyStatus with RxStatus = 011 → EVAL, then DetectDone = 1 with LaneMask = 1111.
4. First attempt finds 0011, WAIT12 expires, second attempt finds 0011 → LaneMask = 0011. Repeat with the second attempt finding 0001 → back to QUIET with DetectDone = 0.
5. Lane 3 never returns PhyStatus, lanes 0–2 detected → 2 ms guard expires; the partial path runs twice with found = 0111 and ends at LaneMask = 0111.
6. Enable dropped mid-DETECT → next cycle state = QUIET, TxDetectRx = 0, TimerEnable = 0. Reset asserted in DONE → all outputs return to their reset values asynchronously.
